reset_sequencer: RTL and testbench

- Per-project reset generator for the user area. Generalises the single-channel async-assert/sync-release reset router.
- Adds a configurable synchroniser depth, a minimum reset hold time, synchronous software reset requests, and staggered release: at most one project leaves reset per release slot, which limits simultaneous switching current.
- Sits between the top-level reset/chip-select logic and the student project instances.

---
 rtl/reset_sequencer_if.sv | 25 ++
 rtl/reset_sequencer.sv | 137 +++++++++++++
 tb/tb_reset_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// Per-project reset bundle between the chip-select logic and the user projects.
interface reset_sequencer_if #(
    parameter int unsigned NUM_PROJECTS = 13
);
    logic [NUM_PROJECTS:1] designs_cs;
    logic [NUM_PROJECTS:1] sw_rst_req;
    logic [NUM_PROJECTS:1] designs_n_rst;
    logic                  busy;

    // Reset/chip-select controller side
    modport master (
        output designs_cs,
        output sw_rst_req,
        input  designs_n_rst,
        input  busy
    );

    // Sequencer side
    modport slave (
        input  designs_cs,
        input  sw_rst_req,
        output designs_n_rst,
        output busy
    );
endinterface

// File: rtl/reset_sequencer.sv
// Per-project reset generator: async assert, synchronised release, minimum hold,
// software reset requests and staggered one-at-a-time release.
module reset_sequencer #(
    parameter int unsigned NUM_PROJECTS = 13,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned HOLD_CYCLES  = 16,
    parameter int unsigned GAP_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    reset_sequencer_if.slave bus
);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned GAP_W  = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_SYNC    = 3'd1,
        ST_HOLD    = 3'd2,
        ST_PENDING = 3'd3,
        ST_RUN     = 3'd4
    } state_t;

    logic [NUM_PROJECTS:1] cause_n;
    logic [NUM_PROJECTS:1] pending;
    logic [NUM_PROJECTS:1] winner;
    logic [NUM_PROJECTS:1] gnt;
    logic [NUM_PROJECTS:1] busy_vec;
    logic                  found;
    logic [GAP_W-1:0]      gap_q;

    // A channel is held in reset by the global reset or its own chip-select hold
    assign cause_n = {NUM_PROJECTS{n_rst}} & ~bus.designs_cs;

    // Lowest-index channel waiting for release
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NUM_PROJECTS; k++) begin
            if (pending[k] && !found) begin
                winner[k] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    // A software request on the winner suppresses the whole grant for this edge
    assign gnt = (gap_q == '0) ? (winner & ~bus.sw_rst_req) : '0;

    // Spacing counter between consecutive releases
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            gap_q <= '0;
        end else if (|gnt) begin
            gap_q <= GAP_W'(GAP_CYCLES);
        end else if (gap_q != '0) begin
            gap_q <= gap_q - GAP_W'(1);
        end
    end

    for (genvar i = 1; i <= NUM_PROJECTS; i++) begin : g_ch
        state_t                 st_q;
        state_t                 st_d;
        logic [HOLD_W-1:0]      hold_q;
        logic [HOLD_W-1:0]      hold_d;
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   n_rst_q;

        // Release synchroniser, cleared the instant the cause asserts
        always_ff @(posedge clk or negedge cause_n[i]) begin
            if (!cause_n[i]) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
            end
        end

        // Channel state, hold counter and registered reset output
        always_ff @(posedge clk or negedge cause_n[i]) begin
            if (!cause_n[i]) begin
                st_q    <= ST_RESET;
                hold_q  <= '0;
                n_rst_q <= 1'b0;
            end else begin
                st_q    <= st_d;
                hold_q  <= hold_d;
                n_rst_q <= (st_d == ST_RUN);
            end
        end

        // Next-state logic; software requests restart the hold window
        always_comb begin
            st_d   = st_q;
            hold_d = hold_q;
            unique case (st_q)
                ST_RESET: begin
                    st_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (sync_q[SYNC_STAGES-2]) begin
                        st_d   = ST_HOLD;
                        hold_d = HOLD_W'(HOLD_CYCLES);
                    end
                end
                ST_HOLD: begin
                    if (bus.sw_rst_req[i]) begin
                        hold_d = HOLD_W'(HOLD_CYCLES);
                    end else if (hold_q == HOLD_W'(1)) begin
                        st_d   = ST_PENDING;
                        hold_d = '0;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                ST_PENDING, ST_RUN: begin
                    if (bus.sw_rst_req[i]) begin
                        st_d   = ST_HOLD;
                        hold_d = HOLD_W'(HOLD_CYCLES);
                    end else if (gnt[i]) begin
                        st_d = ST_RUN;
                    end
                end
                default: begin
                    st_d = ST_RESET;
                end
            endcase
        end

        // Only offer a release once the synchroniser output confirms it
        assign pending[i]            = (st_q == ST_PENDING) && sync_q[SYNC_STAGES-1];
        assign busy_vec[i]           = (st_q inside {ST_SYNC, ST_HOLD, ST_PENDING});
        assign bus.designs_n_rst[i]  = n_rst_q;
    end

    assign bus.busy = |busy_vec;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: two configurations driven together,
// expected outputs from a timestamp-based reference model.
module tb_reset_sequencer;
    localparam int N  = 13;
    localparam int NI = 2;

    typedef struct {
        int          inst;
        logic [N:1]  outv;
        logic        busyv;
        int          edge_no;
        int          kind;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_rst_a, n_rst_b;
    logic [N:1] cs_a, cs_b, sw_a, sw_b;

    reset_sequencer_if #(.NUM_PROJECTS(N)) ifa ();
    reset_sequencer_if #(.NUM_PROJECTS(N)) ifb ();

    assign ifa.designs_cs = cs_a;
    assign ifa.sw_rst_req = sw_a;
    assign ifb.designs_cs = cs_b;
    assign ifb.sw_rst_req = sw_b;

    reset_sequencer #(.NUM_PROJECTS(N), .SYNC_STAGES(2), .HOLD_CYCLES(16), .GAP_CYCLES(4))
        u_dut_a (.clk(clk), .n_rst(n_rst_a), .bus(ifa.slave));
    reset_sequencer #(.NUM_PROJECTS(N), .SYNC_STAGES(3), .HOLD_CYCLES(1), .GAP_CYCLES(0))
        u_dut_b (.clk(clk), .n_rst(n_rst_b), .bus(ifb.slave));

    always #10 clk = ~clk;

    // Scoreboard and counters
    exp_t sb[$];
    event chk_ev;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: per-channel timestamps instead of counters
    int p_sync [NI];
    int p_hold [NI];
    int p_gap  [NI];
    bit m_rst  [NI][1:N];
    bit m_run  [NI][1:N];
    bit m_mask [NI][1:N];
    int m_pend [NI][1:N];
    int m_send [NI][1:N];
    int m_last [NI];
    int k;

    function automatic bit cause(int n, int i);
        if (n == 0) return bit'(n_rst_a & ~cs_a[i]);
        return bit'(n_rst_b & ~cs_b[i]);
    endfunction

    function automatic bit swv(int n, int i);
        if (n == 0) return bit'(sw_a[i]);
        return bit'(sw_b[i]);
    endfunction

    function automatic bit grst(int n);
        return (n == 0) ? bit'(n_rst_a) : bit'(n_rst_b);
    endfunction

    // Asynchronous effects of the inputs right now
    function automatic void model_async(int n);
        for (int i = 1; i <= N; i++) begin
            if (!cause(n, i)) begin
                m_rst[n][i]  = 1'b1;
                m_run[n][i]  = 1'b0;
                m_mask[n][i] = 1'b1;
            end
        end
        if (!grst(n)) m_last[n] = -1000;
    endfunction

    // Effects of clock edge k
    function automatic void model_edge(int n);
        bit pend_now [1:N];
        bit swhit    [1:N];
        int win;
        win = 0;
        for (int i = 1; i <= N; i++) begin
            pend_now[i] = !m_rst[n][i] && !m_run[n][i] && !m_mask[n][i] && (k > m_pend[n][i]);
            swhit[i]    = 1'b0;
            if (pend_now[i] && win == 0) win = i;
        end
        for (int i = 1; i <= N; i++) begin
            if (!cause(n, i)) begin
                m_rst[n][i]  = 1'b1;
                m_run[n][i]  = 1'b0;
                m_mask[n][i] = 1'b1;
            end else if (m_mask[n][i]) begin
                m_mask[n][i] = 1'b0;
                m_rst[n][i]  = 1'b0;
                m_run[n][i]  = 1'b0;
                m_send[n][i] = k + p_sync[n] - 1;
                m_pend[n][i] = k + p_sync[n] - 1 + p_hold[n];
            end else if (!m_rst[n][i] && swv(n, i) && k > m_send[n][i]) begin
                m_pend[n][i] = k + p_hold[n];
                m_run[n][i]  = 1'b0;
                swhit[i]     = 1'b1;
            end
        end
        if (!grst(n)) begin
            m_last[n] = -1000;
        end else if (win != 0 && !swhit[win] && (k - m_last[n]) > p_gap[n]) begin
            m_run[n][win] = 1'b1;
            m_last[n]     = k;
        end
    endfunction

    function automatic void push_exp(int n, int kind);
        exp_t e;
        e.inst    = n;
        e.outv    = '0;
        e.busyv   = 1'b0;
        e.edge_no = k;
        e.kind    = kind;
        for (int i = 1; i <= N; i++) begin
            e.outv[i] = m_run[n][i] & cause(n, i);
            if (!m_rst[n][i] && !m_run[n][i] && cause(n, i)) e.busyv = 1'b1;
        end
        sb.push_back(e);
    endfunction

    // Monitor: compares every queued expectation against the DUT when it is sampled
    initial begin
        exp_t       e;
        logic [N:1] act_o;
        logic       act_b;
        forever begin
            @(negedge clk or chk_ev);
            while (sb.size() > 0) begin
                e     = sb.pop_front();
                act_o = (e.inst == 0) ? ifa.designs_n_rst : ifb.designs_n_rst;
                act_b = (e.inst == 0) ? ifa.busy : ifb.busy;
                n_tests++;
                if (act_o !== e.outv) begin
                    n_fail++;
                    $display("FAIL %s_n_rst inst%0d edge %0d: got %h required %h",
                             (e.kind != 0) ? "async" : "edge", e.inst, e.edge_no, act_o, e.outv);
                end
                n_tests++;
                if (act_b !== e.busyv) begin
                    n_fail++;
                    $display("FAIL %s_busy inst%0d edge %0d: got %b required %b",
                             (e.kind != 0) ? "async" : "edge", e.inst, e.edge_no, act_b, e.busyv);
                end
            end
        end
    end

    // One clock edge: advance the model, queue expectations, return mid low phase
    task automatic tick();
        @(posedge clk);
        k++;
        model_edge(0);
        model_edge(1);
        push_exp(0, 0);
        push_exp(1, 0);
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(int cnt);
        for (int t = 0; t < cnt; t++) tick();
    endtask

    // Check outputs right after an input change, between clock edges
    task automatic async_check();
        model_async(0);
        model_async(1);
        #1;
        push_exp(0, 1);
        push_exp(1, 1);
        ->chk_ev;
    endtask

    task automatic rand_drive(int n);
        logic [N:1] sw;
        logic [N:1] cs;
        int         j;
        sw = '0;
        cs = (n == 0) ? cs_a : cs_b;
        if ($urandom_range(3) == 0) begin
            j = int'($urandom_range(N, 1));
            sw[j] = 1'b1;
        end
        if ($urandom_range(15) == 0) begin
            j = int'($urandom_range(N, 1));
            cs[j] = ~cs[j];
        end
        if (n == 0) begin sw_a = sw; cs_a = cs; end
        else        begin sw_b = sw; cs_b = cs; end
        async_check();
        if ($urandom_range(49) == 0) begin
            j = int'($urandom_range(N, 1));
            if (n == 0) cs_a[j] = ~cs_a[j]; else cs_b[j] = ~cs_b[j];
            async_check();
            if (n == 0) cs_a[j] = ~cs_a[j]; else cs_b[j] = ~cs_b[j];
        end
        if ($urandom_range(199) == 0) begin
            if (n == 0) n_rst_a = 1'b0; else n_rst_b = 1'b0;
            async_check();
            if (n == 0) n_rst_a = 1'b1; else n_rst_b = 1'b1;
        end
    endtask

    initial begin
        p_sync[0] = 2; p_hold[0] = 16; p_gap[0] = 4;
        p_sync[1] = 3; p_hold[1] = 1;  p_gap[1] = 0;
        k = 0;
        for (int n = 0; n < NI; n++) begin
            m_last[n] = -1000;
            for (int i = 1; i <= N; i++) begin
                m_rst[n][i]  = 1'b1;
                m_run[n][i]  = 1'b0;
                m_mask[n][i] = 1'b1;
                m_pend[n][i] = 0;
                m_send[n][i] = 0;
            end
        end
        n_rst_a = 1'b0; n_rst_b = 1'b0;
        cs_a = '0; cs_b = '0; sw_a = '0; sw_b = '0;
        #1;
        async_check();

        // Power-up: held in reset, then released between edges
        ticks(3);
        n_rst_a = 1'b1;
        n_rst_b = 1'b1;
        async_check();
        ticks(90);

        // Chip-select pulse on channel 5 between edges
        cs_a[5] = 1'b1;
        async_check();
        cs_a[5] = 1'b0;
        async_check();
        ticks(25);

        // Single-edge software reset on channel 3
        sw_a[3] = 1'b1;
        ticks(1);
        sw_a = '0;
        ticks(20);

        // Contention: channels 2 and 7 together, then channel 2 again at S+10
        sw_a[2] = 1'b1;
        sw_a[7] = 1'b1;
        sw_b[2] = 1'b1;
        sw_b[7] = 1'b1;
        ticks(1);
        sw_a = '0;
        sw_b = '0;
        ticks(9);
        sw_a[2] = 1'b1;
        ticks(1);
        sw_a = '0;
        ticks(30);

        // Global reset, restart, and a second global pulse mid-sequence
        n_rst_a = 1'b0;
        async_check();
        ticks(1);
        n_rst_a = 1'b1;
        ticks(39);
        n_rst_a = 1'b0;
        async_check();
        n_rst_a = 1'b1;
        async_check();
        ticks(90);

        // Randomised traffic on both configurations
        for (int t = 0; t < 1500; t++) begin
            rand_drive(0);
            rand_drive(1);
            tick();
        end
        sw_a = '0; sw_b = '0; cs_a = '0; cs_b = '0;
        ticks(100);

        @(negedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
